// File: rtl/cacheline_burst_adapter_pkg.sv
// Shared constants, state encoding and address helpers for the cache line-fill /
// writeback burst adapter.
package cacheline_burst_adapter_pkg;

   localparam int CACHELINE_SIZE = 256;
   localparam int BMEM_BEAT_BITS = 64;
   localparam int BURST_LEN      = CACHELINE_SIZE / BMEM_BEAT_BITS;
   localparam int BURST_CNT_BITS = $clog2(BURST_LEN);
   localparam int OFFSET_BITS    = $clog2(CACHELINE_SIZE / 8);
   localparam int SET_BITS       = 4;
   localparam int TAG_BITS       = 32 - SET_BITS - OFFSET_BITS;

   typedef enum logic [2:0] {
      ADP_IDLE    = 3'd0,
      ADP_RD_REQ  = 3'd1,
      ADP_RD_DATA = 3'd2,
      ADP_WR_DATA = 3'd3,
      ADP_DONE    = 3'd4
   } adapter_state_t;

   typedef struct packed {
      logic [TAG_BITS-1:0]    tag;
      logic [SET_BITS-1:0]    set_index;
      logic [OFFSET_BITS-1:0] block_offset;
   } cache_address_t;

   // Keeps tag and set index, clears the byte offset within the line.
   function automatic logic [31:0] line_align(input logic [31:0] addr);
      cache_address_t a;
      a = cache_address_t'(addr);
      a.block_offset = '0;
      return 32'(a);
   endfunction

endpackage

// File: rtl/cacheline_burst_adapter_if.sv
// Cache-side line port (dfp) and memory-side beat bus (bmem) of the burst adapter.
// The master modport is the side that issues requests on that bus.
interface cacheline_dfp_if
   import cacheline_burst_adapter_pkg::*;
#(
   parameter int LINE_BITS = CACHELINE_SIZE
);
   logic [31:0]          dfp_addr;
   logic                 dfp_read;
   logic                 dfp_write;
   logic [LINE_BITS-1:0] dfp_wdata;
   logic [LINE_BITS-1:0] dfp_rdata;
   logic                 dfp_resp;

   modport master (
      output dfp_addr, dfp_read, dfp_write, dfp_wdata,
      input  dfp_rdata, dfp_resp
   );
   modport slave (
      input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
      output dfp_rdata, dfp_resp
   );
endinterface

interface cacheline_bmem_if
   import cacheline_burst_adapter_pkg::*;
#(
   parameter int BEAT_BITS = BMEM_BEAT_BITS
);
   logic [31:0]          bmem_addr;
   logic                 bmem_read;
   logic                 bmem_write;
   logic [BEAT_BITS-1:0] bmem_wdata;
   logic                 bmem_ready;
   logic [BEAT_BITS-1:0] bmem_rdata;
   logic                 bmem_rvalid;

   modport master (
      output bmem_addr, bmem_read, bmem_write, bmem_wdata,
      input  bmem_ready, bmem_rdata, bmem_rvalid
   );
   modport slave (
      input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
      output bmem_ready, bmem_rdata, bmem_rvalid
   );
endinterface

// File: rtl/cacheline_burst_adapter_line_beat_buffer.sv
// One cache line held as BURST_LEN beats: whole-line load for writeback, beat-indexed
// write for fill, beat-indexed read for slicing the writeback into beats.
module line_beat_buffer #(
   parameter int BEAT_BITS = 64,
   parameter int BURST_LEN = 4,
   parameter int CNT_BITS  = $clog2(BURST_LEN)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                load_en,
   input  logic [BURST_LEN*BEAT_BITS-1:0]      load_line,
   input  logic                                beat_we,
   input  logic [CNT_BITS-1:0]                 beat_idx,
   input  logic [BEAT_BITS-1:0]                beat_wdata,
   input  logic [CNT_BITS-1:0]                 rd_idx,
   output logic [BURST_LEN-1:0][BEAT_BITS-1:0] beats,
   output logic [BEAT_BITS-1:0]                rd_beat
);

   logic [BURST_LEN-1:0][BEAT_BITS-1:0] beats_r;

   // Line storage; a whole-line load takes priority over a single-beat fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         beats_r <= '0;
      end else if (load_en) begin
         beats_r <= load_line;
      end else if (beat_we) begin
         beats_r[beat_idx] <= beat_wdata;
      end else begin
         beats_r <= beats_r;
      end
   end

   assign beats   = beats_r;
   assign rd_beat = beats_r[rd_idx];

endmodule

// File: rtl/cacheline_burst_adapter.sv
// Memory-side responder for the cache line port: turns one line read/write into a
// BURST_LEN-beat burst on the backing-memory bus and reports completion with dfp_resp.
module cacheline_burst_adapter
   import cacheline_burst_adapter_pkg::*;
#(
   parameter int LINE_BITS = CACHELINE_SIZE,
   parameter int BEAT_BITS = BMEM_BEAT_BITS,
   parameter int BURST_LEN = LINE_BITS / BEAT_BITS
) (
   input  logic              clk,
   input  logic              rst,
   cacheline_dfp_if.slave    dfp,
   cacheline_bmem_if.master  bmem
);

   localparam int                  CNT_BITS  = $clog2(BURST_LEN);
   localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BURST_LEN - 1);

   adapter_state_t                      state_r;
   logic [CNT_BITS-1:0]                 count_r;
   logic [31:0]                         bmem_addr_r;
   logic                                bmem_read_r;
   logic                                bmem_write_r;
   logic [BEAT_BITS-1:0]                bmem_wdata_r;
   logic [BURST_LEN-1:0][BEAT_BITS-1:0] dfp_rdata_r;
   logic                                dfp_resp_r;

   logic                                load_en_s;
   logic                                beat_we_s;
   logic                                last_beat_s;
   logic [CNT_BITS-1:0]                 rd_idx_s;
   logic [BEAT_BITS-1:0]                rd_beat_s;
   logic [BURST_LEN-1:0][BEAT_BITS-1:0] beats_s;
   logic [BURST_LEN-1:0][BEAT_BITS-1:0] fill_beats_s;

   line_beat_buffer #(
      .BEAT_BITS (BEAT_BITS),
      .BURST_LEN (BURST_LEN),
      .CNT_BITS  (CNT_BITS)
   ) u_line_buf (
      .clk        (clk),
      .rst        (rst),
      .load_en    (load_en_s),
      .load_line  (dfp.dfp_wdata),
      .beat_we    (beat_we_s),
      .beat_idx   (count_r),
      .beat_wdata (bmem.bmem_rdata),
      .rd_idx     (rd_idx_s),
      .beats      (beats_s),
      .rd_beat    (rd_beat_s)
   );

   // Buffer controls; fill_beats_s is the line as it stands once the current beat lands,
   // so the completed fill can be published on the same edge as the last beat.
   always_comb begin
      load_en_s    = 1'b0;
      beat_we_s    = 1'b0;
      rd_idx_s     = count_r + CNT_BITS'(1'b1);
      last_beat_s  = (count_r == LAST_BEAT);
      fill_beats_s = beats_s;
      fill_beats_s[count_r] = bmem.bmem_rdata;
      case (state_r)
         ADP_IDLE:    load_en_s = dfp.dfp_write;
         ADP_RD_DATA: beat_we_s = bmem.bmem_rvalid;
         default: begin
            load_en_s = 1'b0;
            beat_we_s = 1'b0;
         end
      endcase
   end

   // Burst sequencer with all bus-facing outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ADP_IDLE;
         count_r      <= '0;
         bmem_addr_r  <= '0;
         bmem_read_r  <= 1'b0;
         bmem_write_r <= 1'b0;
         bmem_wdata_r <= '0;
         dfp_rdata_r  <= '0;
         dfp_resp_r   <= 1'b0;
      end else begin
         dfp_resp_r <= 1'b0;
         case (state_r)
            ADP_IDLE: begin
               count_r <= '0;
               // A pending read stays asserted by the cache, so write-first is safe.
               if (dfp.dfp_write) begin
                  bmem_addr_r  <= line_align(dfp.dfp_addr);
                  bmem_write_r <= 1'b1;
                  bmem_wdata_r <= dfp.dfp_wdata[BEAT_BITS-1:0];
                  state_r      <= ADP_WR_DATA;
               end else if (dfp.dfp_read) begin
                  bmem_addr_r <= line_align(dfp.dfp_addr);
                  bmem_read_r <= 1'b1;
                  state_r     <= ADP_RD_REQ;
               end else begin
                  state_r <= ADP_IDLE;
               end
            end
            ADP_RD_REQ: begin
               if (bmem.bmem_ready) begin
                  bmem_read_r <= 1'b0;
                  count_r     <= '0;
                  state_r     <= ADP_RD_DATA;
               end else begin
                  state_r <= ADP_RD_REQ;
               end
            end
            ADP_RD_DATA: begin
               if (bmem.bmem_rvalid && last_beat_s) begin
                  count_r     <= '0;
                  dfp_rdata_r <= fill_beats_s;
                  dfp_resp_r  <= 1'b1;
                  state_r     <= ADP_DONE;
               end else if (bmem.bmem_rvalid) begin
                  count_r <= count_r + CNT_BITS'(1'b1);
               end else begin
                  state_r <= ADP_RD_DATA;
               end
            end
            ADP_WR_DATA: begin
               if (bmem.bmem_ready && last_beat_s) begin
                  count_r      <= '0;
                  bmem_write_r <= 1'b0;
                  bmem_wdata_r <= '0;
                  dfp_resp_r   <= 1'b1;
                  state_r      <= ADP_DONE;
               end else if (bmem.bmem_ready) begin
                  count_r      <= count_r + CNT_BITS'(1'b1);
                  bmem_wdata_r <= rd_beat_s;
               end else begin
                  state_r <= ADP_WR_DATA;
               end
            end
            ADP_DONE: begin
               state_r <= ADP_IDLE;
            end
            default: begin
               state_r      <= ADP_IDLE;
               count_r      <= '0;
               bmem_read_r  <= 1'b0;
               bmem_write_r <= 1'b0;
            end
         endcase
      end
   end

   assign dfp.dfp_rdata   = dfp_rdata_r;
   assign dfp.dfp_resp    = dfp_resp_r;
   assign bmem.bmem_addr  = bmem_addr_r;
   assign bmem.bmem_read  = bmem_read_r;
   assign bmem.bmem_write = bmem_write_r;
   assign bmem.bmem_wdata = bmem_wdata_r;

endmodule
